tagged_priority_queue: RTL and testbench
========================================

# tagged_priority_queue

Parametrised, sorted-array priority queue holding {key, tag} entries, replacing the single-width, min-only priority queue of the previous generation. It adds a selectable ordering mode, a payload tag per entry, stable ordering among equal keys, same-cycle push+pop, flush, occupancy count and overflow/underflow flags. It sits between schedulers and consumers wherever the lowest- or highest-key entry must always be available at the head with zero read latency.

## Interface
- DEPTH, 10, number of entries (≥2)
- KEY_W, 32, key width (priority field)
- TAG_W, 8, payload tag width, carried unchanged
- MAX_FIRST, 0, 0 = smallest key at head, 1 = largest key at head
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous clear of all entries
- i_push  in  1  insert request
- i_push_key  in  KEY_W  key to insert
- i_push_tag  in  TAG_W  tag to insert
- i_pop  in  1  remove head request
- o_head_valid  out  1  head entry present (= !o_empty)
- o_head_key  out  KEY_W  head key
- o_head_tag  out  TAG_W  head tag
- o_count  out  CNT_W  number of stored entries
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0
- o_overflow  out  1  one-cycle pulse: push dropped
- o_underflow  out  1  one-cycle pulse: pop on empty ignored

## Operation
- Storage: DEPTH slots, slot 0 = head; occupied slots always contiguous from slot 0 and sorted per MAX_FIRST.
- Head outputs are combinational from slot 0 (show-ahead); o_head_key/tag are 0 when empty.
- Push only: entry inserted behind all entries with key "better or equal" (stable: equal keys leave in arrival order); lower slots shift down one.
- Pop only: slot 0 removed, all slots shift up one; count decrements.
- Push+pop same cycle: current head (value on outputs that cycle) is removed; new entry inserted among the remaining entries with the same stability rule; count unchanged. Legal when full (no overflow) and when empty (push takes effect, pop → underflow pulse, count becomes 1).
- Push while full without pop: dropped, o_overflow pulses, contents unchanged.
- Pop while empty without push: ignored, o_underflow pulses.
- Comparison unsigned, KEY_W bits; tag never affects order.
- i_flush: highest priority over push/pop; next cycle count = 0, slots cleared, no overflow/underflow pulse.
- Reset: all slots, o_count, o_overflow, o_underflow = 0; o_empty = 1, o_full = 0, o_head_valid = 0.

## Timing
- All state updates on posedge CLK; reset asynchronous, takes effect immediately, released synchronously by design.
- Push visible at head (if it is the best key) the cycle after the push edge; o_count/o_full/o_empty update the same edge.
- Pop latency 0: data valid on head outputs during the cycle i_pop is asserted; next head appears after the edge.
- o_overflow/o_underflow registered, high exactly one cycle after the offending edge.
- Reset asserted mid-operation: contents discarded; no partial shift survives.
- Single-cycle throughput: one push and one pop every cycle, indefinitely.

## Structure
- Package tpq_pkg: entry struct typedef parameterised via macros or localparams for {key, tag}, ordering-mode constants (MIN_FIRST=0, MAX_FIRST=1), comparator function `better_or_equal(a,b,mode)`.
- One sub-module tpq_cell: single slot with occupied bit, holds/loads from neighbour above, below or push input based on local compare results; top level generates DEPTH cells and count/flag logic. Target ~250 lines total.

## Test plan
- MIN mode, DEPTH=10: push keys 12,1,2,14,12,3,0,20,25,13 → o_full=1, count=10; ten pops return 0,1,2,3,12,12,13,14,20,25, then o_empty=1.
- Stability: push (12,tag 0xA),(12,0xB),(12,0xC) → pops return tags A,B,C in order; MAX_FIRST=1 with same keys returns 25 first, and equal keys still FIFO.
- Full + push+pop: fill with 1..10, push 0 with pop → popped 1, no overflow, head next cycle = 0, count stays 10; push alone when full → o_overflow pulse, contents unchanged.
- Empty edge cases: pop on empty → o_underflow pulse, count 0; push 7 + pop on empty → underflow pulse, count=1, head=7.
- Flush and reset: fill 5 entries, assert i_flush with i_push → count=0 next cycle, push ignored; assert RSTn mid-stream → all outputs at reset values immediately.
- Random: 10k cycles random push/pop/keys vs golden sorted-list model; head, count, flags match every cycle.

Source files
------------

// File: rtl/tpq_pkg.sv
// Shared types and the key comparator for the tagged priority queue.
package tpq_pkg;

   localparam bit MIN_FIRST = 1'b0;
   localparam bit MAX_FIRST = 1'b1;

   // Comparator operand width; keys are zero-extended to this width.
   localparam int unsigned CMP_W = 64;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_PUSH,
      OP_POP,
      OP_PUSHPOP,
      OP_CLEAR
   } op_t;

   // True when key a may stay ahead of key b (equal keys keep arrival order).
   function automatic logic better_or_equal(input logic [CMP_W-1:0] a,
                                            input logic [CMP_W-1:0] b,
                                            input logic             mode);
      return (mode == MAX_FIRST) ? (a >= b) : (a <= b);
   endfunction

endpackage

// File: rtl/tagged_priority_queue_cell.sv
// One slot of the sorted array: holds, shifts from a neighbour, or captures the push entry.
module tpq_cell
   import tpq_pkg::*;
#(
   parameter int unsigned KEY_W = 32,
   parameter int unsigned TAG_W = 8,
   parameter bit          MODE  = 1'b0,
   parameter bit          HEAD  = 1'b0
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  op_t              op,
   input  logic [KEY_W-1:0] push_key,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             above_occ,
   input  logic [KEY_W-1:0] above_key,
   input  logic [TAG_W-1:0] above_tag,
   input  logic             ge_above,
   input  logic             below_occ,
   input  logic [KEY_W-1:0] below_key,
   input  logic [TAG_W-1:0] below_tag,
   input  logic             ge_below,
   output logic             occ,
   output logic [KEY_W-1:0] key,
   output logic [TAG_W-1:0] tag,
   output logic             ge
);

   logic             nxt_occ;
   logic [KEY_W-1:0] nxt_key;
   logic [TAG_W-1:0] nxt_tag;

   assign ge = occ && better_or_equal(CMP_W'(key), CMP_W'(push_key), MODE);

   // Insert point is the first slot whose own entry is not better-or-equal.
   always_comb begin
      nxt_occ = occ;
      nxt_key = key;
      nxt_tag = tag;
      unique case (op)
         OP_CLEAR: begin
            nxt_occ = 1'b0;
            nxt_key = '0;
            nxt_tag = '0;
         end
         OP_POP: begin
            nxt_occ = below_occ;
            nxt_key = below_key;
            nxt_tag = below_tag;
         end
         OP_PUSH: begin
            if (!ge) begin
               if (HEAD || ge_above) begin
                  nxt_occ = 1'b1;
                  nxt_key = push_key;
                  nxt_tag = push_tag;
               end else begin
                  nxt_occ = above_occ;
                  nxt_key = above_key;
                  nxt_tag = above_tag;
               end
            end
         end
         // Head leaves; the survivors are slots 1.., so compare one slot lower.
         OP_PUSHPOP: begin
            if (ge_below) begin
               nxt_occ = below_occ;
               nxt_key = below_key;
               nxt_tag = below_tag;
            end else if (HEAD || ge) begin
               nxt_occ = 1'b1;
               nxt_key = push_key;
               nxt_tag = push_tag;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RSTn) begin
      if (RSTn) begin
         occ <= 1'b0;
         key <= '0;
         tag <= '0;
      end else begin
         occ <= nxt_occ;
         key <= nxt_key;
         tag <= nxt_tag;
      end
   end

endmodule

// File: rtl/tagged_priority_queue.sv
// Sorted-array priority queue of {key, tag} with show-ahead head, push+pop and flush.
module tagged_priority_queue
#(
   parameter int unsigned  DEPTH     = 10,
   parameter int unsigned  KEY_W     = 32,
   parameter int unsigned  TAG_W     = 8,
   parameter bit           MAX_FIRST = 1'b0,
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [KEY_W-1:0] i_push_key,
   input  logic [TAG_W-1:0] i_push_tag,
   input  logic             i_pop,
   output logic             o_head_valid,
   output logic [KEY_W-1:0] o_head_key,
   output logic [TAG_W-1:0] o_head_tag,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   output logic             o_underflow
);
   import tpq_pkg::*;

   op_t              op;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             unf_q;

   // Index DEPTH is an always-empty sentinel below the last slot.
   logic             occ_a [DEPTH+1];
   logic [KEY_W-1:0] key_a [DEPTH+1];
   logic [TAG_W-1:0] tag_a [DEPTH+1];
   logic             ge_a  [DEPTH+1];

   assign occ_a[DEPTH] = 1'b0;
   assign key_a[DEPTH] = '0;
   assign tag_a[DEPTH] = '0;
   assign ge_a[DEPTH]  = 1'b0;

   assign o_count      = count_q;
   assign o_full       = (count_q == CNT_W'(DEPTH));
   assign o_empty      = (count_q == '0);
   assign o_head_valid = !o_empty;
   assign o_head_key   = key_a[0];
   assign o_head_tag   = tag_a[0];
   assign o_overflow   = ovf_q;
   assign o_underflow  = unf_q;

   always_comb begin
      op = OP_HOLD;
      if (i_flush)                 op = OP_CLEAR;
      else if (i_push && i_pop)    op = OP_PUSHPOP;
      else if (i_push && !o_full)  op = OP_PUSH;
      else if (i_pop && !o_empty)  op = OP_POP;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      localparam int unsigned UP = (i == 0) ? 0 : i - 1;

      tpq_cell #(
         .KEY_W (KEY_W),
         .TAG_W (TAG_W),
         .MODE  (MAX_FIRST),
         .HEAD  (i == 0)
      ) u_cell (
         .CLK       (CLK),
         .RSTn      (RSTn),
         .op        (op),
         .push_key  (i_push_key),
         .push_tag  (i_push_tag),
         .above_occ (occ_a[UP]),
         .above_key (key_a[UP]),
         .above_tag (tag_a[UP]),
         .ge_above  ((i == 0) ? 1'b0 : ge_a[UP]),
         .below_occ (occ_a[i+1]),
         .below_key (key_a[i+1]),
         .below_tag (tag_a[i+1]),
         .ge_below  (ge_a[i+1]),
         .occ       (occ_a[i]),
         .key       (key_a[i]),
         .tag       (tag_a[i]),
         .ge        (ge_a[i])
      );
   end

   // Occupancy and one-cycle error pulses; flush suppresses both pulses.
   always_ff @(posedge CLK or posedge RSTn) begin
      if (RSTn) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         ovf_q <= !i_flush && i_push && !i_pop && o_full;
         unf_q <= !i_flush && i_pop && o_empty;
         unique case (op)
            OP_CLEAR:   count_q <= '0;
            OP_PUSH:    count_q <= count_q + CNT_W'(1);
            OP_POP:     count_q <= count_q - CNT_W'(1);
            OP_PUSHPOP: if (o_empty) count_q <= CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tagged_priority_queue.sv
// Drives MIN- and MAX-ordered queues with identical stimulus and scoreboards both against sorted lists.
module tb_tagged_priority_queue;

   localparam int unsigned DEPTH = 10;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_push = 1'b0;
   logic [31:0] i_push_key = '0;
   logic [7:0]  i_push_tag = '0;
   logic        i_pop = 1'b0;

   logic        hv   [2];
   logic [31:0] hk   [2];
   logic [7:0]  ht   [2];
   logic [3:0]  cnt  [2];
   logic        full [2];
   logic        empt [2];
   logic        ovf  [2];
   logic        unf  [2];

   tagged_priority_queue #(.DEPTH(DEPTH), .KEY_W(32), .TAG_W(8), .MAX_FIRST(1'b0)) u_min (
      .CLK(CLK), .RSTn(RSTn), .i_flush(i_flush), .i_push(i_push),
      .i_push_key(i_push_key), .i_push_tag(i_push_tag), .i_pop(i_pop),
      .o_head_valid(hv[0]), .o_head_key(hk[0]), .o_head_tag(ht[0]), .o_count(cnt[0]),
      .o_full(full[0]), .o_empty(empt[0]), .o_overflow(ovf[0]), .o_underflow(unf[0]));

   tagged_priority_queue #(.DEPTH(DEPTH), .KEY_W(32), .TAG_W(8), .MAX_FIRST(1'b1)) u_max (
      .CLK(CLK), .RSTn(RSTn), .i_flush(i_flush), .i_push(i_push),
      .i_push_key(i_push_key), .i_push_tag(i_push_tag), .i_pop(i_pop),
      .o_head_valid(hv[1]), .o_head_key(hk[1]), .o_head_tag(ht[1]), .o_count(cnt[1]),
      .o_full(full[1]), .o_empty(empt[1]), .o_overflow(ovf[1]), .o_underflow(unf[1]));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] key;
      logic [7:0]  tag;
   } ent_t;

   typedef struct packed {
      bit          m;
      logic        hv;
      logic [31:0] hk;
      logic [7:0]  ht;
      logic [3:0]  cnt;
      logic        full;
      logic        empty;
      logic        ovf;
      logic        unf;
   } exp_t;

   ent_t mq [2][$];
   exp_t exp_q [$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, expv);
      end
   endtask

   // Reference: keep each list sorted; a new entry goes before the first strictly worse key.
   task automatic model_step(input int m, input logic p, input logic [31:0] k,
                             input logic [7:0] t, input logic q, input logic f,
                             output logic o_ovf, output logic o_unf);
      int   pos;
      ent_t e;
      o_ovf = 1'b0;
      o_unf = 1'b0;
      if (f) begin
         mq[m].delete();
      end else begin
         o_unf = q && (mq[m].size() == 0);
         o_ovf = p && !q && (mq[m].size() == DEPTH);
         if (q && mq[m].size() > 0) void'(mq[m].pop_front());
         if (p && !o_ovf) begin
            pos = mq[m].size();
            for (int j = 0; j < mq[m].size(); j++) begin
               if ((m == 1) ? (k > mq[m][j].key) : (k < mq[m][j].key)) begin
                  pos = j;
                  break;
               end
            end
            e.key = k;
            e.tag = t;
            mq[m].insert(pos, e);
         end
      end
   endtask

   task automatic cyc(input logic p, input logic [31:0] k, input logic [7:0] t,
                      input logic q, input logic f);
      exp_t r;
      logic o, u;
      @(negedge CLK);
      i_push = p; i_push_key = k; i_push_tag = t; i_pop = q; i_flush = f;
      for (int m = 0; m < 2; m++) begin
         model_step(m, p, k, t, q, f, o, u);
         r.m     = (m == 1);
         r.cnt   = 4'(mq[m].size());
         r.hv    = (mq[m].size() > 0);
         r.hk    = r.hv ? mq[m][0].key : 32'd0;
         r.ht    = r.hv ? mq[m][0].tag : 8'd0;
         r.full  = (mq[m].size() == DEPTH);
         r.empty = (mq[m].size() == 0);
         r.ovf   = o;
         r.unf   = u;
         exp_q.push_back(r);
      end
   endtask

   task automatic check_reset_state(input string tagname);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s m%0d count", tagname, m), 32'(cnt[m]), 32'd0);
         chk($sformatf("%s m%0d empty", tagname, m), 32'(empt[m]), 32'd1);
         chk($sformatf("%s m%0d full", tagname, m), 32'(full[m]), 32'd0);
         chk($sformatf("%s m%0d head_valid", tagname, m), 32'(hv[m]), 32'd0);
         chk($sformatf("%s m%0d head_key", tagname, m), hk[m], 32'd0);
         chk($sformatf("%s m%0d ovf_unf", tagname, m), 32'({ovf[m], unf[m]}), 32'd0);
      end
   endtask

   // Monitor: compare every output of both queues one step after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("m%0d head_valid", e.m), 32'(hv[e.m]), 32'(e.hv));
            chk($sformatf("m%0d head_key", e.m), hk[e.m], e.hk);
            chk($sformatf("m%0d head_tag", e.m), 32'(ht[e.m]), 32'(e.ht));
            chk($sformatf("m%0d count", e.m), 32'(cnt[e.m]), 32'(e.cnt));
            chk($sformatf("m%0d full", e.m), 32'(full[e.m]), 32'(e.full));
            chk($sformatf("m%0d empty", e.m), 32'(empt[e.m]), 32'(e.empty));
            chk($sformatf("m%0d overflow", e.m), 32'(ovf[e.m]), 32'(e.ovf));
            chk($sformatf("m%0d underflow", e.m), 32'(unf[e.m]), 32'(e.unf));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog t=%0t act=timeout exp=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] plan_keys [10];
      plan_keys = '{32'd12, 32'd1, 32'd2, 32'd14, 32'd12, 32'd3, 32'd0, 32'd20, 32'd25, 32'd13};

      #3;
      check_reset_state("por");
      @(negedge CLK);
      RSTn = 1'b0;
      cyc(0, 0, 0, 0, 0);

      // Ordered fill, full flag, ten pops, then one pop too many.
      for (int i = 0; i < 10; i++) cyc(1, plan_keys[i], 8'(i), 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);

      // Equal keys must leave in arrival order.
      cyc(1, 12, 8'hA, 0, 0);
      cyc(1, 12, 8'hB, 0, 0);
      cyc(1, 12, 8'hC, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

      // Full queue: push+pop, then push alone overflows, then flush beats push.
      for (int i = 1; i <= 10; i++) cyc(1, 32'(i), 8'(i + 16), 0, 0);
      cyc(1, 0, 8'h55, 1, 0);
      cyc(1, 5, 8'h66, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 9, 8'h77, 0, 1);
      cyc(0, 0, 0, 0, 0);

      // Empty queue: pop alone, then push+pop.
      cyc(0, 0, 0, 1, 0);
      cyc(1, 7, 8'h07, 1, 0);
      cyc(0, 0, 0, 1, 0);

      // Five entries then flush with a concurrent push.
      for (int i = 0; i < 5; i++) cyc(1, 32'(30 - i), 8'(i), 0, 0);
      cyc(1, 3, 8'h33, 0, 1);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 4; i++) cyc(1, 32'(i * 7), 8'(i), 0, 0);
      @(negedge CLK);
      i_push = 0; i_pop = 0; i_flush = 0;
      #2;
      RSTn = 1'b1;
      #1;
      check_reset_state("midrst");
      mq[0].delete();
      mq[1].delete();
      @(negedge CLK);
      RSTn = 1'b0;
      cyc(0, 0, 0, 0, 0);

      // Random traffic with a narrow key range to exercise ties.
      for (int n = 0; n < 10000; n++) begin
         cyc(($urandom_range(0, 99) < 55), 32'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45),
             ($urandom_range(0, 199) == 0));
      end

      @(negedge CLK);
      i_push = 0; i_pop = 0; i_flush = 0;
      repeat (2) @(posedge CLK);
      #2;
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
